// File: rtl/steer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : steer_ctrl_pkg
// Brief    : Shared game constants for steering input: timing defaults and
//            direction FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package steer_ctrl_pkg;

    // Steering timing defaults at a 50 MHz system clock
    localparam int c_DEBOUNCE_CYCLES_DEF = 500000;   // 10 ms
    localparam int c_REPEAT_DELAY_DEF    = 2500000;  // 50 ms
    localparam int c_REPEAT_PERIOD_DEF   = 250000;   // 5 ms

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE_L = 2'd1,
        ST_MOVE_R = 2'd2
    } steer_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One spare bit above the largest count keeps saturation checks simple
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/steer_debounce.sv
`default_nettype none
// ============================================================================
// Module   : steer_debounce
// Brief    : Two-flop synchronizer followed by a consecutive-sample debouncer
//            for one raw push button.
// Revision : 1.0 - initial release
// ============================================================================
module steer_debounce
    import steer_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic btn_db
);

    localparam int               c_LAST_INT = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(c_LAST_INT);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             w_differ;
    logic             w_accept;

    assign w_differ = r_sync[1] ^ r_db;
    // The sample being taken now is the DEBOUNCE_CYCLES-th differing one
    assign w_accept = (r_cnt >= c_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
            r_cnt  <= '0;
            r_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn};
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_db  <= ~r_db;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    assign btn_db = r_db;

endmodule
`default_nettype wire

// File: rtl/steer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : steer_ctrl
// Brief    : Debounced left/right steering buttons to one-cycle move strobes
//            with initial delay and periodic auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module steer_ctrl
    import steer_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = c_REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = c_REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_left,
    input  logic btn_right,
    input  logic enable,
    output logic left,
    output logic right,
    output logic left_db,
    output logic right_db
);

    localparam int c_CNT_W = cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [c_CNT_W-1:0] c_DELAY  = c_CNT_W'(REPEAT_DELAY);
    localparam logic [c_CNT_W-1:0] c_PERIOD = c_CNT_W'(REPEAT_PERIOD);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    steer_state_t       r_state;
    steer_state_t       w_state_nxt;
    logic [c_CNT_W-1:0] r_rpt_cnt;
    logic [c_CNT_W-1:0] w_rpt_cnt_nxt;
    logic               r_left;
    logic               r_right;
    logic               w_left_nxt;
    logic               w_right_nxt;
    logic               w_req_l;
    logic               w_req_r;
    logic               w_rpt_due;

    steer_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (c_CNT_W)
    ) u_db_left (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn_left),
        .btn_db (left_db)
    );

    steer_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (c_CNT_W)
    ) u_db_right (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn_right),
        .btn_db (right_db)
    );

    // Both pressed cancels; a frozen game requests nothing
    assign w_req_l   = enable & left_db & ~right_db;
    assign w_req_r   = enable & right_db & ~left_db;
    assign w_rpt_due = (r_rpt_cnt <= c_ONE);

    always_comb begin
        w_state_nxt   = ST_IDLE;
        w_rpt_cnt_nxt = '0;
        w_left_nxt    = 1'b0;
        w_right_nxt   = 1'b0;
        case (r_state)
            ST_MOVE_L: begin
                if (w_req_l) begin
                    w_state_nxt = ST_MOVE_L;
                    if (w_rpt_due) begin
                        w_left_nxt    = 1'b1;
                        w_rpt_cnt_nxt = c_PERIOD;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt - c_ONE;
                    end
                end else if (w_req_r) begin
                    w_state_nxt   = ST_MOVE_R;
                    w_right_nxt   = 1'b1;
                    w_rpt_cnt_nxt = c_DELAY;
                end
            end
            ST_MOVE_R: begin
                if (w_req_r) begin
                    w_state_nxt = ST_MOVE_R;
                    if (w_rpt_due) begin
                        w_right_nxt   = 1'b1;
                        w_rpt_cnt_nxt = c_PERIOD;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt - c_ONE;
                    end
                end else if (w_req_l) begin
                    w_state_nxt   = ST_MOVE_L;
                    w_left_nxt    = 1'b1;
                    w_rpt_cnt_nxt = c_DELAY;
                end
            end
            default: begin
                if (w_req_l) begin
                    w_state_nxt   = ST_MOVE_L;
                    w_left_nxt    = 1'b1;
                    w_rpt_cnt_nxt = c_DELAY;
                end else if (w_req_r) begin
                    w_state_nxt   = ST_MOVE_R;
                    w_right_nxt   = 1'b1;
                    w_rpt_cnt_nxt = c_DELAY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
            r_left    <= 1'b0;
            r_right   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_left    <= w_left_nxt;
            r_right   <= w_right_nxt;
        end
    end

    assign left  = r_left;
    assign right = r_right;

endmodule
`default_nettype wire

// File: tb/tb_steer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_steer_ctrl
// Brief    : Self-checking bench for steer_ctrl against a cycle-level
//            behavioural model of the steering rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_steer_ctrl;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic enable = 1'b1;
    logic left, right, left_db, right_db;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [1:0] m_pipe_l, m_pipe_r;
    int         m_run_l, m_run_r;
    logic       m_db_l, m_db_r;
    int         m_dir, m_age;
    logic       m_left, m_right;

    steer_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .enable    (enable),
        .left      (left),
        .right     (right),
        .left_db   (left_db),
        .right_db  (right_db)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dut_vec();
        return {left, right, left_db, right_db};
    endfunction

    function automatic logic [3:0] model_vec();
        return {m_left, m_right, m_db_l, m_db_r};
    endfunction

    // Strobe schedule measured from the first cycle of a continuous request
    function automatic bit fire_at(input int age);
        return (age == 0) || (age >= RD && ((age - RD) % RP) == 0);
    endfunction

    task automatic model_reset();
        m_pipe_l = 2'b00; m_pipe_r = 2'b00;
        m_run_l  = 0;     m_run_r  = 0;
        m_db_l   = 1'b0;  m_db_r   = 1'b0;
        m_dir    = 0;     m_age    = 0;
        m_left   = 1'b0;  m_right  = 1'b0;
    endtask

    task automatic model_edge();
        int req;
        req = 0;
        if (enable && m_db_l && !m_db_r)      req = 1;
        else if (enable && m_db_r && !m_db_l) req = 2;
        if (req == 0) begin
            m_dir = 0;
            m_age = 0;
        end else if (req != m_dir) begin
            m_dir = req;
            m_age = 0;
        end else begin
            m_age++;
        end
        m_left  = (req == 1) && fire_at(m_age);
        m_right = (req == 2) && fire_at(m_age);
        // Debounced level flips after D consecutive disagreeing synced samples
        if (m_pipe_l[1] != m_db_l) begin
            m_run_l++;
            if (m_run_l == D) begin m_db_l = ~m_db_l; m_run_l = 0; end
        end else m_run_l = 0;
        if (m_pipe_r[1] != m_db_r) begin
            m_run_r++;
            if (m_run_r == D) begin m_db_r = ~m_db_r; m_run_r = 0; end
        end else m_run_r = 0;
        m_pipe_l = {m_pipe_l[0], btn_left};
        m_pipe_r = {m_pipe_r[0], btn_right};
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
    endtask

    task automatic gap(input int n);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        enable    = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) tick();
        n_assert++; if (left !== 1'b0)     begin n_fail++; $display("FAIL reset_left got=%b exp=0", left); end
        n_assert++; if (right !== 1'b0)    begin n_fail++; $display("FAIL reset_right got=%b exp=0", right); end
        n_assert++; if (left_db !== 1'b0)  begin n_fail++; $display("FAIL reset_left_db got=%b exp=0", left_db); end
        n_assert++; if (right_db !== 1'b0) begin n_fail++; $display("FAIL reset_right_db got=%b exp=0", right_db); end
        reset = 1'b0;
        gap(3);
    endtask

    task automatic test_single_tap();
        logic exp_l;
        btn_left = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            if (k == 21) btn_left = 1'b0;
            tick();
            n_assert++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL tap_model cyc=%0d got=%b exp=%b", k, dut_vec(), model_vec());
            end
            exp_l = (k <= 20) ? (k == 7 || (k >= 17 && (k - 17) % 3 == 0)) : (k == 23 || k == 26);
            n_assert++;
            if (left !== exp_l || right !== 1'b0) begin
                n_fail++; $display("FAIL tap_strobe cyc=%0d got=%b%b exp=%b0", k, left, right, exp_l);
            end
            n_assert++;
            if (left_db !== (k >= 6 && k <= 25)) begin
                n_fail++; $display("FAIL tap_left_db cyc=%0d got=%b exp=%b", k, left_db, (k >= 6 && k <= 25));
            end
        end
        gap(5);
    endtask

    task automatic test_hold();
        logic exp_r;
        btn_right = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            if (k == 41) btn_right = 1'b0;
            tick();
            n_assert++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL hold_model cyc=%0d got=%b exp=%b", k, dut_vec(), model_vec());
            end
            exp_r = (k == 7) || (k >= 17 && k <= 46 && (k - 17) % 3 == 0);
            n_assert++;
            if (right !== exp_r || left !== 1'b0) begin
                n_fail++; $display("FAIL hold_strobe cyc=%0d got=%b%b exp=0%b", k, left, right, exp_r);
            end
            n_assert++;
            if (right_db !== (k >= 6 && k <= 45)) begin
                n_fail++; $display("FAIL hold_right_db cyc=%0d got=%b exp=%b", k, right_db, (k >= 6 && k <= 45));
            end
        end
        gap(5);
    endtask

    task automatic test_bounce();
        for (int k = 1; k <= 20; k++) begin
            btn_left = ((k - 1) % 4) != 3;
            tick();
            n_assert++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL bounce_model cyc=%0d got=%b exp=%b", k, dut_vec(), model_vec());
            end
            n_assert++;
            if (left_db !== 1'b0 || left !== 1'b0) begin
                n_fail++; $display("FAIL bounce_quiet cyc=%0d got=%b%b exp=00", k, left_db, left);
            end
        end
        btn_left = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            n_assert++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL bounce_model2 cyc=%0d got=%b exp=%b", k, dut_vec(), model_vec());
            end
            n_assert++;
            if (left !== (k == 7 || k == 17)) begin
                n_fail++; $display("FAIL bounce_strobe cyc=%0d got=%b exp=%b", k, left, (k == 7 || k == 17));
            end
        end
        gap(12);
    endtask

    task automatic test_both();
        int n_strobes;
        logic exp_l;
        n_strobes = 0;
        btn_left  = 1'b1;
        for (int k = 1; k <= 74; k++) begin
            if (k == 36) btn_right = 1'b1;
            if (k == 56) btn_right = 1'b0;
            tick();
            n_assert++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL both_model cyc=%0d got=%b exp=%b", k, dut_vec(), model_vec());
            end
            if (left) n_strobes++;
            if (k == 35) begin
                n_assert++;
                if (n_strobes != 8) begin
                    n_fail++; $display("FAIL both_count8 got=%0d exp=8", n_strobes);
                end
            end
            if (k >= 42) begin
                exp_l = (k == 62 || k == 72);
                n_assert++;
                if (left !== exp_l || right !== 1'b0) begin
                    n_fail++; $display("FAIL both_strobe cyc=%0d got=%b%b exp=%b0", k, left, right, exp_l);
                end
            end
        end
        gap(12);
    endtask

    task automatic test_enable();
        logic exp_l;
        btn_left = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            if (k == 23) enable = 1'b0;
            if (k == 31) enable = 1'b1;
            tick();
            n_assert++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL enable_model cyc=%0d got=%b exp=%b", k, dut_vec(), model_vec());
            end
            if (k <= 22)      exp_l = (k == 7 || k == 17 || k == 20);
            else if (k <= 30) exp_l = 1'b0;
            else              exp_l = (k == 31 || k == 41);
            n_assert++;
            if (left !== exp_l) begin
                n_fail++; $display("FAIL enable_strobe cyc=%0d got=%b exp=%b", k, left, exp_l);
            end
        end
        gap(12);
    endtask

    task automatic test_reset_mid();
        btn_left = 1'b1;
        for (int k = 1; k <= 16; k++) tick();
        @(posedge clk);
        model_edge();
        #1;
        n_assert++;
        if (left !== 1'b1 || m_left !== 1'b1) begin
            n_fail++; $display("FAIL rmid_pre got=%b model=%b exp=1", left, m_left);
        end
        reset = 1'b1;
        model_reset();
        #1;
        n_assert++;
        if (dut_vec() !== 4'b0000) begin
            n_fail++; $display("FAIL rmid_async got=%b exp=0000", dut_vec());
        end
        @(negedge clk);
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_assert++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL rmid_model cyc=%0d got=%b exp=%b", k, dut_vec(), model_vec());
            end
            n_assert++;
            if (left !== (k == 7) || left_db !== (k >= 6)) begin
                n_fail++; $display("FAIL rmid_restart cyc=%0d got=%b%b exp=%b%b", k, left, left_db, (k == 7), (k >= 6));
            end
        end
        gap(12);
    endtask

    task automatic test_random();
        for (int k = 1; k <= 700; k++) begin
            if ($urandom_range(11) == 0) btn_left  = ~btn_left;
            if ($urandom_range(13) == 0) btn_right = ~btn_right;
            if ($urandom_range(49) == 0) enable    = ~enable;
            tick();
            n_assert++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL rand_model cyc=%0d got=%b exp=%b", k, dut_vec(), model_vec());
            end
            n_assert++;
            if (left === 1'b1 && right === 1'b1) begin
                n_fail++; $display("FAIL rand_exclusive cyc=%0d got=11 exp=not both", k);
            end
        end
        gap(12);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_tap();
        test_hold();
        test_bounce();
        test_both();
        test_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
